// File: rtl/cnn_window_sequencer_if.sv
// Handshake and data bundle between the row-register bank, the window sequencer and the CNN core.
// The image and window buses travel together with the valid/ready pair that qualifies them.
interface cnn_window_sequencer_if #(
  parameter int DATAWIDTH_BUS = 8
);
  localparam int NPOS = DATAWIDTH_BUS - 2;
  localparam int CW   = $clog2(NPOS);

  logic                                   CNNSeq_Start_In;
  logic [DATAWIDTH_BUS*DATAWIDTH_BUS-1:0] CNNSeq_Image_InBUS;
  logic                                   CNNSeq_Ready_In;
  logic [8:0]                             CNNSeq_Window_OutBUS;
  logic [CW-1:0]                          CNNSeq_Row_OutBUS;
  logic [CW-1:0]                          CNNSeq_Col_OutBUS;
  logic                                   CNNSeq_Valid_Out;
  logic                                   CNNSeq_Last_Out;
  logic                                   CNNSeq_Busy_Out;
  logic                                   CNNSeq_Done_Out;

  modport slave (
    input  CNNSeq_Start_In, CNNSeq_Image_InBUS, CNNSeq_Ready_In,
    output CNNSeq_Window_OutBUS, CNNSeq_Row_OutBUS, CNNSeq_Col_OutBUS,
           CNNSeq_Valid_Out, CNNSeq_Last_Out, CNNSeq_Busy_Out, CNNSeq_Done_Out
  );

  modport master (
    output CNNSeq_Start_In, CNNSeq_Image_InBUS, CNNSeq_Ready_In,
    input  CNNSeq_Window_OutBUS, CNNSeq_Row_OutBUS, CNNSeq_Col_OutBUS,
           CNNSeq_Valid_Out, CNNSeq_Last_Out, CNNSeq_Busy_Out, CNNSeq_Done_Out
  );
endinterface

// File: rtl/cnn_window_sequencer.sv
// Snapshots an 8x8 binary image on start and streams every 3x3 window in raster order,
// then pulses done once the final window has been accepted.
module cnn_window_sequencer #(
  parameter int DATAWIDTH_BUS = 8
) (
  input  logic                         CNNSeq_CLOCK_50,
  input  logic                         CNNSeq_Reset_InHigh,
  cnn_window_sequencer_if.slave        seq_if,
  output logic [1:0]                   state_dbg
);
  localparam int W    = DATAWIDTH_BUS;
  localparam int NPOS = W - 2;
  localparam int CW   = $clog2(NPOS);
  localparam int IW   = $clog2(W * W);
  localparam logic [CW-1:0] LAST_POS = CW'(NPOS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W*W-1:0]  snap_q, snap_d;
  logic [CW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [8:0]      window_q, window_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            xfer;

  // Window bit 3*i+j is pixel(r+i, c+j); column 0 is the MSB of each row slice.
  function automatic logic [8:0] window_at(input logic [W*W-1:0] img,
                                           input logic [CW-1:0]  r,
                                           input logic [CW-1:0]  c);
    logic [8:0]    w;
    logic [IW-1:0] idx;
    int            rr;
    int            cc;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        rr = int'(r) + i;
        cc = int'(c) + j;
        idx = IW'(rr * W + (W - 1 - cc));
        w[3*i+j] = img[idx];
      end
    end
    return w;
  endfunction

  // Valid/ready: a window transfers on any edge where valid and ready are both high;
  // valid is a flop so it never depends on ready within a cycle, and the window,
  // row and column hold steady until the transfer happens.
  assign xfer = valid_q && seq_if.CNNSeq_Ready_In;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    row_d   = row_q;
    col_d   = col_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (seq_if.CNNSeq_Start_In) begin
          snap_d  = seq_if.CNNSeq_Image_InBUS;
          row_d   = '0;
          col_d   = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (xfer) begin
          if ((row_q == LAST_POS) && (col_q == LAST_POS)) begin
            row_d   = '0;
            col_d   = '0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else if (col_q == LAST_POS) begin
            col_d = '0;
            row_d = row_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Outputs are precomputed from next-state values so they line up with the counters.
    valid_d  = (state_d == S_SCAN);
    busy_d   = valid_d;
    last_d   = valid_d && (row_d == LAST_POS) && (col_d == LAST_POS);
    window_d = valid_d ? window_at(snap_d, row_d, col_d) : 9'd0;
  end

  always_ff @(posedge CNNSeq_CLOCK_50) begin
    if (CNNSeq_Reset_InHigh) begin
      state_q  <= S_IDLE;
      snap_q   <= '0;
      row_q    <= '0;
      col_q    <= '0;
      window_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      snap_q   <= snap_d;
      row_q    <= row_d;
      col_q    <= col_d;
      window_q <= window_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign seq_if.CNNSeq_Window_OutBUS = window_q;
  assign seq_if.CNNSeq_Row_OutBUS    = row_q;
  assign seq_if.CNNSeq_Col_OutBUS    = col_q;
  assign seq_if.CNNSeq_Valid_Out     = valid_q;
  assign seq_if.CNNSeq_Last_Out      = last_q;
  assign seq_if.CNNSeq_Busy_Out      = busy_q;
  assign seq_if.CNNSeq_Done_Out      = done_q;
  assign state_dbg                   = state_q;
endmodule

// File: doc/cnn_window_sequencer.md
# cnn_window_sequencer

Sequences the convolution stage of the CNN datapath. On a start request it snapshots the 8x8 binary image held in the eight row registers (filled over SPI). It then presents every 3x3 window, in raster order, to the downstream MAC/convolution unit over a valid/ready handshake. It signals completion with a one-cycle done pulse. It sits between the row-register bank and the CNN core, replacing the direct start wiring from the SPI slave.

## Interface

Parameters:
- DATAWIDTH_BUS, 8: image width and height in pixels; one row register per row. Kernel is fixed at 3x3, so there are NPOS = DATAWIDTH_BUS-2 positions per axis.

Ports:
- CNNSeq_CLOCK_50  in  1: single clock, the same clock as the row registers.
- CNNSeq_Reset_InHigh  in  1: synchronous, active-high reset.
- CNNSeq_Start_In  in  1: start request. Sampled only in IDLE.
- CNNSeq_Image_InBUS  in  DATAWIDTH_BUS*DATAWIDTH_BUS: concatenated row-register outputs.
  - Row r occupies [r*DATAWIDTH_BUS +: DATAWIDTH_BUS].
  - Within a row, the MSB is column 0.
- CNNSeq_Ready_In  in  1: downstream accepts the current window.
- CNNSeq_Window_OutBUS  out  9: current 3x3 window. Bit 3*i+j = pixel(row+i, col+j), with i,j in 0..2.
- CNNSeq_Row_OutBUS  out  clog2(NPOS): window top-left row.
- CNNSeq_Col_OutBUS  out  clog2(NPOS): window top-left column.
- CNNSeq_Valid_Out  out  1: window, row and column outputs are valid.
- CNNSeq_Last_Out  out  1: current window is the final one, at (NPOS-1, NPOS-1).
- CNNSeq_Busy_Out  out  1: high while in SCAN.
- CNNSeq_Done_Out  out  1: one-cycle pulse after the last window is accepted.

## Operation

- States: IDLE, SCAN, DONE.
- IDLE, with Start_In=1 at a clock edge:
  - The image is copied into an internal snapshot register at that edge.
  - Row and column counters are set to 0.
  - State goes to SCAN.
- SCAN:
  - Valid_Out=1.
  - The window is built combinationally or registered from the snapshot; it must match the counters in the same cycle.
  - A transfer occurs at an edge where Valid_Out and Ready_In are both 1.
  - On a transfer, the column increments. When the column equals NPOS-1, it wraps to 0 and the row increments.
  - A transfer with Last_Out=1 moves the state to DONE.
- DONE: Done_Out=1 for exactly one cycle, then the state returns to IDLE.
- Start_In in SCAN or DONE is ignored, not queued.
- Changes on Image_InBUS after the snapshot edge have no effect until the next accepted start.
- Window count per run is NPOS*NPOS, which is 36 at the default.
- Reset (synchronous, at any state):
  - State goes to IDLE.
  - Snapshot, counters and all outputs are cleared to 0.
  - A reset mid-scan aborts the run and produces no Done_Out pulse.
- Reset has priority over Start_In in the same cycle.

## Timing

- Reset values: Window_OutBUS=0, Row=0, Col=0, Valid=0, Last=0, Busy=0, Done=0.
- Start latency: Start_In high at edge k, so Valid_Out and Busy_Out are high in the cycle after edge k.
- Handshake:
  - Valid_Out never drops without a transfer, except on reset.
  - Window, Row and Col are stable while Valid=1 and Ready=0.
  - The next window appears in the cycle immediately after a transfer, with no bubble.
- Ready_In may be high before Valid_Out. No combinational path from Ready_In to Valid_Out is allowed.
- With Ready_In held high: 36 consecutive valid cycles, then Done_Out is high in cycle 37 after the start edge, then IDLE.
- Busy_Out is low in DONE. A new start can be accepted at the first IDLE edge after DONE.
- Last_Out = Valid_Out when Row = NPOS-1 and Col = NPOS-1.

## Test plan

- All rows 8'hFF, start, Ready=1:
  - 36 windows, each 9'h1FF, in raster order (0,0), (0,1) … (5,5).
  - Last_Out only on window 36.
  - Done pulse 1 cycle later; Busy low afterwards.
- Checkerboard (even rows 8'hAA, odd rows 8'h55):
  - Window (0,0) = 9'h155 and (0,1) = 9'h0AA.
  - Windows alternate by the parity of row+col.
- Backpressure: Ready low for 5 cycles at window (2,3), then high:
  - Valid stays 1 and the window, Row and Col are unchanged for all 5 cycles.
  - The next window is (2,4).
  - Total windows are still 36.
- Snapshot and start-ignore: during SCAN, change the image to all zero and pulse Start:
  - The output continues from the original snapshot.
  - No restart occurs and the window count is still 36.
- Reset at window (3,1):
  - The next cycle has all outputs 0 and no Done pulse.
  - A following Start begins again at (0,0).
- Start and reset high together in IDLE: the block stays in IDLE and Valid stays 0.
